// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and the matching receiver).
//   DEFAULT_FREQ_HZ / DEFAULT_BAUD_RATE : default system clock and line rate
//   uart_state_e                        : frame FSM state encoding
//   bit_cycles()                        : clock cycles per line bit (truncating)
package uart_pkg;

  localparam int DEFAULT_FREQ_HZ   = 12_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int bit_cycles(input int freq_hz, input int baud_rate);
    return freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst    : clock, async active-high reset (empties the FIFO)
//   push, din   : write strobe and data (ignored while full)
//   pop, dout   : read strobe (ignored while empty); dout shows the head entry
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter: 1 start bit, NUM_DATA_BITS data bits LSB first,
// 1 stop bit, no parity.
//   sys_clk, rst : clock, async active-high reset (aborts any frame, drops FIFO)
//   data_in      : payload, written when data_valid && data_ready
//   data_ready   : FIFO has room
//   tx_out       : registered serial line, idle high
//   tx_busy      : a frame is on the line
//   tx_done      : one-cycle pulse at the end of each stop bit
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int FREQ_HZ       = DEFAULT_FREQ_HZ,
  parameter int BAUD_RATE     = DEFAULT_BAUD_RATE,
  parameter int NUM_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [NUM_DATA_BITS-1:0] data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_done
);

  localparam int BIT_CYCLES = bit_cycles(FREQ_HZ, BAUD_RATE);
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W      = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DATA_BITS - 1);

  uart_state_e              state, state_nxt;
  logic [CNT_W-1:0]         baud_cnt, baud_nxt;
  logic [IDX_W-1:0]         bit_idx, bit_nxt;
  logic [NUM_DATA_BITS-1:0] shreg, shreg_nxt, shreg_shift;
  logic                     line_nxt, done_nxt;
  logic                     fifo_pop, fifo_full, fifo_empty, bit_end;
  logic [NUM_DATA_BITS-1:0] fifo_dout;

  // Full refuses the push even when the FSM pops on the same edge.
  assign data_ready  = !fifo_full;
  assign tx_busy     = (state != ST_IDLE);
  assign bit_end     = (baud_cnt == BAUD_LAST);
  assign shreg_shift = shreg >> 1;

  sync_fifo #(
    .WIDTH (NUM_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (data_valid && data_ready),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= shreg_nxt;
      tx_out   <= line_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Next-state logic also computes the next line level, so tx_out is a flop.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    line_nxt  = tx_out;
    done_nxt  = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        line_nxt = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_nxt = fifo_dout;
          baud_nxt  = '0;
          line_nxt  = 1'b0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          line_nxt  = shreg[0];
          state_nxt = ST_DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == IDX_LAST) begin
            line_nxt  = 1'b1;
            state_nxt = ST_STOP;
          end else begin
            bit_nxt   = bit_idx + 1'b1;
            shreg_nxt = shreg_shift;
            line_nxt  = shreg_shift[0];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          done_nxt = 1'b1;
          // Chain straight into the next start bit: no idle gap between frames.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shreg_nxt = fifo_dout;
            line_nxt  = 1'b0;
            state_nxt = ST_START;
          end else begin
            line_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
